uart_core: RTL and testbench

Parametrised full-duplex UART, the successor to the fixed 8N1 UART used on the debug/console path. It adds configurable data width, parity and stop bits, 16x-oversampled RX with majority vote and false-start rejection, ready/valid handshakes on both directions, and per-cause error pulses. It sits between an on-chip byte stream (CSR bridge or FIFO) and the two board UART pins.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_tick_gen.sv | 30 +++
 rtl/uart_core.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings, FSM state types and elaboration helpers for the parametrised UART.
package uart_pkg;

  localparam int unsigned PARITY_NONE   = 0;
  localparam int unsigned PARITY_EVEN   = 1;
  localparam int unsigned PARITY_ODD    = 2;
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  // Clocks per oversample tick, rounded to nearest and never below one.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned per_tick;
    int unsigned div_val;
    per_tick = baud * oversample;
    div_val  = (clk_freq + per_tick / 2) / per_tick;
    return (div_val < 32'd1) ? 32'd1 : div_val;
  endfunction

  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int unsigned width,
                                      input int unsigned mode);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < width) p = p ^ data[i];
    end
    return (mode == PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Restartable divider: one-cycle tick every DIV clocks, first tick DIV clocks after clear.
module uart_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == CNT_LAST);
  assign tick    = at_last && !clear;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || at_last) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART with configurable framing, oversampled majority-vote RX and
// ready/valid handshakes on both byte-stream sides.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 48000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned OVERSAMPLE    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_vld,
  output logic                 tx_rdy,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_uart,
  input  logic                 rx_uart,
  output logic                 rx_vld,
  input  logic                 rx_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun_err
);

  localparam int unsigned DIV        = calc_div(CLK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);
  localparam bit          HAS_PARITY = (PARITY != PARITY_NONE);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] TICK_S2   = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  // ---------------------------------------------------------------- TX
  tx_state_e              tx_state_q, tx_state_d;
  logic [TICK_W-1:0]      tx_tick_cnt_q, tx_tick_cnt_d;
  logic [BIT_W-1:0]       tx_bit_cnt_q, tx_bit_cnt_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_line_q, tx_line_d;
  logic                   tx_tick, tx_clear, tx_bit_end;
  logic [MAX_DATA_BITS-1:0] tx_data_ext;

  uart_tick_gen #(.DIV(DIV)) u_tx_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tx_clear),
    .tick  (tx_tick)
  );

  always_comb begin
    tx_data_ext                 = '0;
    tx_data_ext[DATA_BITS-1:0]  = tx_data;
  end

  assign tx_rdy     = (tx_state_q == TxIdle);
  assign tx_uart    = tx_line_q;
  assign tx_bit_end = tx_tick && (tx_tick_cnt_q == TICK_LAST);

  always_comb begin
    tx_state_d    = tx_state_q;
    tx_tick_cnt_d = tx_tick_cnt_q;
    tx_bit_cnt_d  = tx_bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    tx_par_d      = tx_par_q;
    tx_clear      = 1'b0;
    if (tx_tick)    tx_tick_cnt_d = tx_tick_cnt_q + 1'b1;
    if (tx_bit_end) tx_tick_cnt_d = '0;

    unique case (tx_state_q)
      TxIdle: begin
        if (tx_vld) begin
          tx_state_d    = TxStart;
          tx_shift_d    = tx_data;
          tx_par_d      = parity_bit(tx_data_ext, DATA_BITS, PARITY);
          tx_clear      = 1'b1;
          tx_tick_cnt_d = '0;
          tx_bit_cnt_d  = '0;
        end
      end
      TxStart: if (tx_bit_end) tx_state_d = TxData;
      TxData: begin
        if (tx_bit_end) begin
          if (tx_bit_cnt_q == BIT_LAST) begin
            tx_bit_cnt_d = '0;
            tx_state_d   = HAS_PARITY ? TxParity : TxStop;
          end else begin
            tx_bit_cnt_d = tx_bit_cnt_q + 1'b1;
            tx_shift_d   = tx_shift_q >> 1;
          end
        end
      end
      TxParity: if (tx_bit_end) tx_state_d = TxStop;
      TxStop: begin
        if (tx_bit_end) begin
          if (tx_bit_cnt_q == STOP_LAST) begin
            tx_state_d   = TxIdle;
            tx_bit_cnt_d = '0;
          end else begin
            tx_bit_cnt_d = tx_bit_cnt_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    // Line level follows the next state so the pin is a clean flop output.
    case (tx_state_d)
      TxStart:  tx_line_d = 1'b0;
      TxData:   tx_line_d = tx_shift_d[0];
      TxParity: tx_line_d = tx_par_d;
      default:  tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q    <= TxIdle;
      tx_tick_cnt_q <= '0;
      tx_bit_cnt_q  <= '0;
      tx_shift_q    <= '0;
      tx_par_q      <= 1'b0;
      tx_line_q     <= 1'b1;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_tick_cnt_q <= tx_tick_cnt_d;
      tx_bit_cnt_q  <= tx_bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      tx_par_q      <= tx_par_d;
      tx_line_q     <= tx_line_d;
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_e              rx_state_q, rx_state_d;
  logic [TICK_W-1:0]      rx_tick_cnt_q, rx_tick_cnt_d;
  logic [BIT_W-1:0]       rx_bit_cnt_q, rx_bit_cnt_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic [1:0]             rx_samp_q, rx_samp_d;
  logic                   rx_perr_q, rx_perr_d;
  logic                   rx_meta_q, rx_s_q, rx_prev_q;
  logic                   rx_tick, rx_clear, rx_bit_end, rx_decide, rx_bit;
  logic                   frame_ok, frame_bad, parity_bad;
  logic [MAX_DATA_BITS-1:0] rx_shift_ext;
  logic                   rx_vld_q, rx_vld_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_ferr_q, rx_perr_out_q, rx_oerr_q, rx_oerr_d;

  uart_tick_gen #(.DIV(DIV)) u_rx_tick (
    .clk   (clk),
    .reset (reset),
    .clear (rx_clear),
    .tick  (rx_tick)
  );

  always_comb begin
    rx_shift_ext                = '0;
    rx_shift_ext[DATA_BITS-1:0] = rx_shift_q;
  end

  assign rx_bit_end = rx_tick && (rx_tick_cnt_q == TICK_LAST);
  assign rx_decide  = rx_tick && (rx_tick_cnt_q == TICK_S2);
  assign rx_bit     = (rx_samp_q[0] & rx_samp_q[1]) | (rx_samp_q[0] & rx_s_q) |
                      (rx_samp_q[1] & rx_s_q);

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_tick_cnt_d = rx_tick_cnt_q;
    rx_bit_cnt_d  = rx_bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_samp_d     = rx_samp_q;
    rx_perr_d     = rx_perr_q;
    rx_clear      = 1'b0;
    frame_ok      = 1'b0;
    frame_bad     = 1'b0;
    parity_bad    = 1'b0;
    if (rx_tick)    rx_tick_cnt_d = rx_tick_cnt_q + 1'b1;
    if (rx_bit_end) rx_tick_cnt_d = '0;
    if (rx_tick && (rx_tick_cnt_q == TICK_S0)) rx_samp_d[0] = rx_s_q;
    if (rx_tick && (rx_tick_cnt_q == TICK_S1)) rx_samp_d[1] = rx_s_q;

    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s_q) begin
          rx_state_d    = RxStart;
          rx_clear      = 1'b1;
          rx_tick_cnt_d = '0;
          rx_bit_cnt_d  = '0;
          rx_perr_d     = 1'b0;
        end
      end
      RxStart: begin
        if (rx_decide && rx_bit) rx_state_d = RxIdle;
        else if (rx_bit_end)     rx_state_d = RxData;
      end
      RxData: begin
        if (rx_decide) rx_shift_d = {rx_bit, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_end) begin
          if (rx_bit_cnt_q == BIT_LAST) begin
            rx_bit_cnt_d = '0;
            rx_state_d   = HAS_PARITY ? RxParity : RxStop;
          end else begin
            rx_bit_cnt_d = rx_bit_cnt_q + 1'b1;
          end
        end
      end
      RxParity: begin
        if (rx_decide)  rx_perr_d = (rx_bit != parity_bit(rx_shift_ext, DATA_BITS, PARITY));
        if (rx_bit_end) rx_state_d = RxStop;
      end
      RxStop: begin
        // Leave at mid-bit; IDLE re-arms only once the line has been seen high.
        if (rx_decide) begin
          rx_state_d = RxIdle;
          if (!rx_bit)        frame_bad  = 1'b1;
          else if (rx_perr_q) parity_bad = 1'b1;
          else                frame_ok   = 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    rx_vld_d  = rx_vld_q;
    rx_data_d = rx_data_q;
    rx_oerr_d = 1'b0;
    if (rx_vld_q && rx_rdy) rx_vld_d = 1'b0;
    if (frame_ok) begin
      if (rx_vld_q && !rx_rdy) begin
        rx_oerr_d = 1'b1;
      end else begin
        rx_vld_d  = 1'b1;
        rx_data_d = rx_shift_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RxIdle;
      rx_tick_cnt_q <= '0;
      rx_bit_cnt_q  <= '0;
      rx_shift_q    <= '0;
      rx_samp_q     <= '0;
      rx_perr_q     <= 1'b0;
      rx_vld_q      <= 1'b0;
      rx_data_q     <= '0;
      rx_ferr_q     <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_oerr_q     <= 1'b0;
    end else begin
      rx_meta_q     <= rx_uart;
      rx_s_q        <= rx_meta_q;
      rx_prev_q     <= rx_s_q;
      rx_state_q    <= rx_state_d;
      rx_tick_cnt_q <= rx_tick_cnt_d;
      rx_bit_cnt_q  <= rx_bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_samp_q     <= rx_samp_d;
      rx_perr_q     <= rx_perr_d;
      rx_vld_q      <= rx_vld_d;
      rx_data_q     <= rx_data_d;
      rx_ferr_q     <= frame_bad;
      rx_perr_out_q <= parity_bad;
      rx_oerr_q     <= rx_oerr_d;
    end
  end

  assign rx_vld         = rx_vld_q;
  assign rx_data        = rx_data_q;
  assign rx_frame_err   = rx_ferr_q;
  assign rx_parity_err  = rx_perr_out_q;
  assign rx_overrun_err = rx_oerr_q;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench: an 8N1 instance (a) and a 7E2 instance (b) with optional loopback.
module tb_uart_core;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       tx_vld_a, tx_rdy_a, tx_uart_a, rx_uart_a, rx_vld_a, rx_rdy_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic       fe_a, pe_a, oe_a;

  logic       tx_vld_b, tx_rdy_b, tx_uart_b, rx_uart_b, rx_vld_b, rx_rdy_b;
  logic [6:0] tx_data_b, rx_data_b;
  logic       fe_b, pe_b, oe_b;
  logic       loop_en, rx_drv_b;

  assign rx_uart_b = loop_en ? tx_uart_b : rx_drv_b;

  uart_core #(
    .CLK_FREQUENCY(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)
  ) dut_a (
    .clk(clk), .reset(reset), .tx_vld(tx_vld_a), .tx_rdy(tx_rdy_a), .tx_data(tx_data_a),
    .tx_uart(tx_uart_a), .rx_uart(rx_uart_a), .rx_vld(rx_vld_a), .rx_rdy(rx_rdy_a),
    .rx_data(rx_data_a), .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_overrun_err(oe_a)
  );

  uart_core #(
    .CLK_FREQUENCY(1600000), .BAUD_RATE(100000), .DATA_BITS(7),
    .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(16)
  ) dut_b (
    .clk(clk), .reset(reset), .tx_vld(tx_vld_b), .tx_rdy(tx_rdy_b), .tx_data(tx_data_b),
    .tx_uart(tx_uart_b), .rx_uart(rx_uart_b), .rx_vld(rx_vld_b), .rx_rdy(rx_rdy_b),
    .rx_data(rx_data_b), .rx_frame_err(fe_b), .rx_parity_err(pe_b), .rx_overrun_err(oe_b)
  );

  int errors = 0;
  int checks = 0;

  // RX observation counters, refreshed by sample_rx
  int         n_vld, n_fe, n_pe, n_oe, first_vld, cyc;
  logic [8:0] got;

  // Reference frame: start 0, data LSB first, optional parity, stop 1s.
  function automatic logic [15:0] make_frame(input logic [8:0] word, input int dbits,
                                             input int pmode, input int stops,
                                             output int nbits);
    logic [15:0] f;
    int pos;
    int ones;
    f = '0;
    pos = 1;
    ones = 0;
    for (int i = 0; i < dbits; i++) begin
      f[pos] = word[i];
      if (word[i]) ones++;
      pos++;
    end
    if (pmode != 0) begin
      f[pos] = (pmode == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
      pos++;
    end
    for (int i = 0; i < stops; i++) begin
      f[pos] = 1'b1;
      pos++;
    end
    nbits = pos;
    return f;
  endfunction

  task automatic clear_stats();
    n_vld = 0; n_fe = 0; n_pe = 0; n_oe = 0; first_vld = -1; cyc = 0; got = '0;
  endtask

  task automatic sample_rx(input bit sel_b);
    cyc++;
    if (sel_b) begin
      if (rx_vld_b) begin n_vld++; got = {2'b00, rx_data_b}; if (first_vld < 0) first_vld = cyc; end
      if (fe_b) n_fe++;
      if (pe_b) n_pe++;
      if (oe_b) n_oe++;
    end else begin
      if (rx_vld_a) begin n_vld++; got = {1'b0, rx_data_a}; if (first_vld < 0) first_vld = cyc; end
      if (fe_a) n_fe++;
      if (pe_a) n_pe++;
      if (oe_a) n_oe++;
    end
  endtask

  task automatic drive_rx(input bit sel_b, input logic [15:0] f, input int nbits, input int idle);
    for (int b = 0; b < nbits; b++) begin
      if (sel_b) rx_drv_b = f[b]; else rx_uart_a = f[b];
      repeat (16) begin @(posedge clk); #1; sample_rx(sel_b); end
    end
    if (sel_b) rx_drv_b = 1'b1; else rx_uart_a = 1'b1;
    repeat (idle) begin @(posedge clk); #1; sample_rx(sel_b); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_vld_a = 0; tx_data_a = '0; rx_uart_a = 1; rx_rdy_a = 0;
    tx_vld_b = 0; tx_data_b = '0; rx_drv_b = 1; rx_rdy_b = 0; loop_en = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (tx_rdy_a !== 1'b1) begin errors++; $display("FAIL reset tx_rdy_a: got %b want 1", tx_rdy_a); end
    checks++; if (tx_uart_a !== 1'b1) begin errors++; $display("FAIL reset tx_uart_a: got %b want 1", tx_uart_a); end
    checks++; if (rx_vld_a !== 1'b0) begin errors++; $display("FAIL reset rx_vld_a: got %b want 0", rx_vld_a); end
    checks++; if (rx_data_a !== 8'h00) begin errors++; $display("FAIL reset rx_data_a: got %h want 00", rx_data_a); end
    checks++; if ({fe_a, pe_a, oe_a} !== 3'b000) begin errors++; $display("FAIL reset errs_a: got %b want 000", {fe_a, pe_a, oe_a}); end
    checks++; if (tx_rdy_b !== 1'b1) begin errors++; $display("FAIL reset tx_rdy_b: got %b want 1", tx_rdy_b); end
    checks++; if (tx_uart_b !== 1'b1) begin errors++; $display("FAIL reset tx_uart_b: got %b want 1", tx_uart_b); end
    checks++; if (rx_data_b !== 7'h00) begin errors++; $display("FAIL reset rx_data_b: got %h want 00", rx_data_b); end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_tx_frame(input logic [7:0] word);
    logic [15:0] f;
    int nb;
    f = make_frame({1'b0, word}, 8, 0, 1, nb);
    checks++; if (tx_rdy_a !== 1'b1) begin errors++; $display("FAIL tx idle rdy: got %b want 1", tx_rdy_a); end
    tx_data_a = word;
    tx_vld_a  = 1'b1;
    @(posedge clk); #1;
    tx_vld_a = 1'b0;
    for (int k = 0; k < nb * 16; k++) begin
      checks++;
      if (tx_uart_a !== f[k/16]) begin
        errors++; $display("FAIL tx line %h clk %0d: got %b want %b", word, k, tx_uart_a, f[k/16]);
      end
      checks++;
      if (tx_rdy_a !== 1'b0) begin
        errors++; $display("FAIL tx busy rdy clk %0d: got %b want 0", k, tx_rdy_a);
      end
      @(posedge clk); #1;
    end
    checks++; if (tx_rdy_a !== 1'b1) begin errors++; $display("FAIL tx end rdy: got %b want 1", tx_rdy_a); end
    checks++; if (tx_uart_a !== 1'b1) begin errors++; $display("FAIL tx end line: got %b want 1", tx_uart_a); end
  endtask

  task automatic test_rx_clean();
    logic [7:0]  w;
    logic [15:0] f;
    int nb;
    rx_rdy_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = 8'($urandom);
      f = make_frame({1'b0, w}, 8, 0, 1, nb);
      clear_stats();
      drive_rx(1'b0, f, nb, 20);
      checks++; if (n_vld !== 1) begin errors++; $display("FAIL rx count: got %0d want 1", n_vld); end
      checks++; if (got !== {1'b0, w}) begin errors++; $display("FAIL rx data: got %h want %h", got, w); end
      checks++; if (first_vld !== 157) begin errors++; $display("FAIL rx latency: got %0d want 157", first_vld); end
      checks++; if (n_fe + n_pe + n_oe !== 0) begin errors++; $display("FAIL rx clean errs: got %0d want 0", n_fe + n_pe + n_oe); end
    end
  endtask

  task automatic test_frame_err_glitch();
    logic [15:0] f;
    int nb;
    rx_rdy_a = 1'b1;
    f = make_frame(9'h096, 8, 0, 1, nb);
    f[nb-1] = 1'b0;
    clear_stats();
    drive_rx(1'b0, f, nb, 30);
    checks++; if (n_fe !== 1) begin errors++; $display("FAIL frame_err pulses: got %0d want 1", n_fe); end
    checks++; if (n_vld !== 0) begin errors++; $display("FAIL frame_err vld: got %0d want 0", n_vld); end
    checks++; if (n_pe + n_oe !== 0) begin errors++; $display("FAIL frame_err others: got %0d want 0", n_pe + n_oe); end
    clear_stats();
    rx_uart_a = 1'b0;
    repeat (6) begin @(posedge clk); #1; sample_rx(1'b0); end
    rx_uart_a = 1'b1;
    repeat (200) begin @(posedge clk); #1; sample_rx(1'b0); end
    checks++; if (n_vld !== 0) begin errors++; $display("FAIL glitch vld: got %0d want 0", n_vld); end
    checks++; if (n_fe + n_pe + n_oe !== 0) begin errors++; $display("FAIL glitch errs: got %0d want 0", n_fe + n_pe + n_oe); end
  endtask

  task automatic test_parity_err();
    logic [15:0] f;
    int nb;
    loop_en  = 1'b0;
    rx_rdy_b = 1'b1;
    f = make_frame(9'h03C, 7, 1, 2, nb);
    f[8] = ~f[8];
    clear_stats();
    drive_rx(1'b1, f, nb, 20);
    checks++; if (n_pe !== 1) begin errors++; $display("FAIL parity_err pulses: got %0d want 1", n_pe); end
    checks++; if (n_vld !== 0) begin errors++; $display("FAIL parity_err vld: got %0d want 0", n_vld); end
    checks++; if (n_fe + n_oe !== 0) begin errors++; $display("FAIL parity_err others: got %0d want 0", n_fe + n_oe); end
  endtask

  task automatic test_overrun();
    logic [15:0] f;
    int nb;
    int hs;
    rx_rdy_a = 1'b0;
    clear_stats();
    f = make_frame(9'h011, 8, 0, 1, nb);
    drive_rx(1'b0, f, nb, 4);
    f = make_frame(9'h022, 8, 0, 1, nb);
    drive_rx(1'b0, f, nb, 20);
    checks++; if (n_oe !== 1) begin errors++; $display("FAIL overrun pulses: got %0d want 1", n_oe); end
    checks++; if (n_fe + n_pe !== 0) begin errors++; $display("FAIL overrun others: got %0d want 0", n_fe + n_pe); end
    checks++; if (rx_vld_a !== 1'b1) begin errors++; $display("FAIL overrun vld: got %b want 1", rx_vld_a); end
    checks++; if (rx_data_a !== 8'h11) begin errors++; $display("FAIL overrun data: got %h want 11", rx_data_a); end
    rx_rdy_a = 1'b1;
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      if (rx_vld_a && rx_rdy_a) hs++;
      @(posedge clk); #1;
    end
    checks++; if (hs !== 1) begin errors++; $display("FAIL overrun handshakes: got %0d want 1", hs); end
    checks++; if (rx_vld_a !== 1'b0) begin errors++; $display("FAIL overrun vld after: got %b want 0", rx_vld_a); end
  endtask

  task automatic test_loopback();
    logic [6:0] words [6];
    int got_n;
    int lp_pe;
    int lp_fe;
    for (int i = 0; i < 6; i++) words[i] = 7'($urandom);
    loop_en  = 1'b1;
    rx_rdy_b = 1'b1;
    got_n = 0; lp_pe = 0; lp_fe = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          bit hs;
          int t;
          tx_data_b = words[i];
          tx_vld_b  = 1'b1;
          hs = 1'b0;
          t  = 0;
          while (!hs && t < 1000) begin
            hs = tx_rdy_b;
            @(posedge clk); #1;
            t++;
          end
          checks++; if (hs !== 1'b1) begin errors++; $display("FAIL loopback tx accept %0d: got %b want 1", i, hs); end
        end
        tx_vld_b = 1'b0;
      end
      begin
        for (int t = 0; t < 1600; t++) begin
          @(posedge clk); #1;
          if (rx_vld_b) begin
            checks++;
            if (got_n >= 6) begin
              errors++; $display("FAIL loopback extra word: got %h want none", rx_data_b);
            end else if (rx_data_b !== words[got_n]) begin
              errors++; $display("FAIL loopback word %0d: got %h want %h", got_n, rx_data_b, words[got_n]);
            end
            got_n++;
          end
          if (pe_b) lp_pe++;
          if (fe_b) lp_fe++;
        end
      end
    join
    checks++; if (got_n !== 6) begin errors++; $display("FAIL loopback count: got %0d want 6", got_n); end
    checks++; if (lp_pe !== 0) begin errors++; $display("FAIL loopback parity_err: got %0d want 0", lp_pe); end
    checks++; if (lp_fe !== 0) begin errors++; $display("FAIL loopback frame_err: got %0d want 0", lp_fe); end
    loop_en = 1'b0;
  endtask

  task automatic test_reset_mid_tx();
    tx_data_a = 8'($urandom);
    tx_vld_a  = 1'b1;
    @(posedge clk); #1;
    tx_vld_a = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx_uart_a !== 1'b1) begin errors++; $display("FAIL mid reset line: got %b want 1", tx_uart_a); end
    checks++; if (tx_rdy_a !== 1'b1) begin errors++; $display("FAIL mid reset rdy: got %b want 1", tx_rdy_a); end
    reset = 1'b0;
    @(posedge clk); #1;
    test_tx_frame(8'h5A);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_frame(8'hA5);
    test_rx_clean();
    test_frame_err_glitch();
    test_parity_err();
    test_overrun();
    test_loopback();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
